// File: rtl/conway_pkg.sv
// Shared Conway board-stream character set and the decoder state encoding.
// The display side imports the same character constants.
package conway_pkg;

    localparam logic [7:0] ESC      = 8'd27;
    localparam logic [7:0] LBRACKET = 8'd91;
    localparam logic [7:0] SEMI     = 8'd59;
    localparam logic [7:0] CHAR_H   = 8'd72;
    localparam logic [7:0] CR       = 8'd13;
    localparam logic [7:0] LF       = 8'd10;
    localparam logic [7:0] ALIVE    = 8'd79;
    localparam logic [7:0] DEAD     = 8'd32;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_ESC1,
        ST_ESC2,
        ST_ESC3,
        ST_CELL,
        ST_CR,
        ST_LF
    } dec_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_board_decoder_if.sv
// Byte stream valid/ready link between a UART receiver (master) and the board decoder (slave).
interface uart_board_decoder_if;
    import conway_pkg::*;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/uart_board_decoder.sv
// Locks on ESC [ ; H, parses WIDTH x HEIGHT cell characters with CR/LF row breaks into a shadow
// bitmap and publishes it to board only once the final cell of a well-formed frame arrives.
module uart_board_decoder
    import conway_pkg::*;
#(
    parameter int         WIDTH      = 8,
    parameter int         HEIGHT     = 8,
    parameter logic [7:0] ALIVE_CHAR = 8'd79,
    parameter logic [7:0] DEAD_CHAR  = 8'd32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    uart_board_decoder_if.slave       rx,
    output logic [WIDTH*HEIGHT-1:0]   board,
    output logic                      frame_done,
    output logic [7:0]                frame_count,
    output logic                      frame_error,
    output logic [7:0]                err_count
);

    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int NC = WIDTH * HEIGHT;
    localparam int IW = (NC > 1) ? $clog2(NC) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    dec_state_e        state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [NC-1:0]     shadow_q, shadow_d;
    logic [NC-1:0]     board_q, board_d;
    logic [7:0]        fcnt_q, fcnt_d;
    logic [7:0]        ecnt_q, ecnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ready_q;
    logic              accept;
    logic              bad;
    logic [7:0]        b;
    logic [IW-1:0]     cell_idx;

    assign accept   = rx.in_valid & ready_q;
    assign b        = rx.in_data;
    assign cell_idx = IW'(row_q) * IW'(WIDTH) + IW'(col_q);

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        shadow_d = shadow_q;
        board_d  = board_q;
        fcnt_d   = fcnt_q;
        ecnt_d   = ecnt_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        bad      = 1'b0;
        if (accept) begin
            unique case (state_q)
                ST_HUNT: if (b == ESC) state_d = ST_ESC1;
                ST_ESC1: if (b == LBRACKET) state_d = ST_ESC2; else bad = 1'b1;
                ST_ESC2: if (b == SEMI)     state_d = ST_ESC3; else bad = 1'b1;
                ST_ESC3: begin
                    if (b == CHAR_H) begin
                        state_d = ST_CELL;
                        col_d   = '0;
                        row_d   = '0;
                    end else bad = 1'b1;
                end
                ST_CELL: begin
                    if (b == ALIVE_CHAR || b == DEAD_CHAR) begin
                        shadow_d[cell_idx] = (b == ALIVE_CHAR);
                        if (col_q == COL_LAST) begin
                            // Final cell commits directly; the last row carries no CR/LF.
                            if (row_q == ROW_LAST) begin
                                board_d = shadow_d;
                                done_d  = 1'b1;
                                fcnt_d  = fcnt_q + 8'd1;
                                state_d = ST_HUNT;
                            end else state_d = ST_CR;
                        end else col_d = col_q + 1'b1;
                    end else bad = 1'b1;
                end
                ST_CR: if (b == CR) state_d = ST_LF; else bad = 1'b1;
                ST_LF: begin
                    if (b == LF) begin
                        state_d = ST_CELL;
                        col_d   = '0;
                        row_d   = row_q + 1'b1;
                    end else bad = 1'b1;
                end
                default: state_d = ST_HUNT;
            endcase
            // A stray ESC is treated as the start of the next frame.
            if (bad) begin
                err_d   = 1'b1;
                ecnt_d  = sat_inc8(ecnt_q);
                state_d = (b == ESC) ? ST_ESC1 : ST_HUNT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_HUNT;
            col_q    <= '0;
            row_q    <= '0;
            shadow_q <= '0;
            board_q  <= '0;
            fcnt_q   <= '0;
            ecnt_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            shadow_q <= shadow_d;
            board_q  <= board_d;
            fcnt_q   <= fcnt_d;
            ecnt_q   <= ecnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ready_q  <= 1'b1;
        end
    end

    assign rx.in_ready  = ready_q;
    assign board        = board_q;
    assign frame_done   = done_q;
    assign frame_error  = err_q;
    assign frame_count  = fcnt_q;
    assign err_count    = ecnt_q;

endmodule

// File: tb/tb_uart_board_decoder.sv
// Scoreboard bench for uart_board_decoder: the driver queues the expected pulse for each frame,
// the monitor pops and compares whenever frame_done or frame_error fires.
module tb_uart_board_decoder;
    import conway_pkg::*;

    typedef struct {
        logic [1:0]  kind;   // {done, error}
        logic [63:0] board;
        logic [7:0]  fc;
        logic [7:0]  ec;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] board;
    logic        frame_done, frame_error;
    logic [7:0]  frame_count, err_count;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        sb[$];
    logic [7:0]  fq[$];
    logic [63:0] exp_board = '0;
    logic [7:0]  exp_fc = '0;
    logic [7:0]  exp_ec = '0;

    uart_board_decoder_if bus();

    uart_board_decoder #(.WIDTH(8), .HEIGHT(8), .ALIVE_CHAR(8'd79), .DEAD_CHAR(8'd32)) dut (
        .clk(clk), .rst_n(rst_n), .rx(bus), .board(board), .frame_done(frame_done),
        .frame_count(frame_count), .frame_error(frame_error), .err_count(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && (frame_done || frame_error)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {62'd0, frame_done, frame_error}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_kind", {62'd0, frame_done, frame_error}, {62'd0, e.kind});
                chk("board", board, e.board);
                chk("frame_count", {56'd0, frame_count}, {56'd0, e.fc});
                chk("err_count", {56'd0, err_count}, {56'd0, e.ec});
                chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic push_err();
        exp_t e;
        exp_ec = (exp_ec == 8'hFF) ? exp_ec : exp_ec + 8'd1;
        e = '{kind: 2'b01, board: exp_board, fc: exp_fc, ec: exp_ec, cyc: cyc + 1};
        sb.push_back(e);
    endtask

    task automatic gen_frame(input logic [63:0] b);
        fq.delete();
        fq.push_back(ESC); fq.push_back(LBRACKET); fq.push_back(SEMI); fq.push_back(CHAR_H);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) fq.push_back(b[r*8+c] ? ALIVE : DEAD);
            if (r < 7) begin fq.push_back(CR); fq.push_back(LF); end
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        bus.in_data  = v;
        bus.in_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Frames are 82 bytes; bad_idx < 0 means well formed, nbytes truncates the frame.
    task automatic send_frame(input logic [63:0] b, input int bad_idx, input logic [7:0] bad_val,
                              input int nbytes);
        gen_frame(b);
        for (int i = 0; i < nbytes; i++) begin
            if (i == bad_idx) begin
                push_err();
                send_byte(bad_val);
            end else begin
                if (i == 81 && bad_idx < 0) begin
                    exp_t e;
                    exp_board = b;
                    exp_fc    = exp_fc + 8'd1;
                    e = '{kind: 2'b10, board: exp_board, fc: exp_fc, ec: exp_ec, cyc: cyc + 1};
                    sb.push_back(e);
                end
                send_byte(fq[i]);
            end
        end
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_board = '0; exp_fc = '0; exp_ec = '0;
        @(negedge clk);
        chk("ready_after_reset", {63'd0, bus.in_ready}, 64'd1);
    endtask

    initial begin
        logic [7:0] hello[7];
        logic [63:0] fa, fcc, fd, fe, ff;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("rst_board", board, 64'd0);
        chk("rst_frame_count", {56'd0, frame_count}, 64'd0);
        chk("rst_err_count", {56'd0, err_count}, 64'd0);
        chk("rst_pulses", {62'd0, frame_done, frame_error}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {63'd0, bus.in_ready}, 64'd1);

        // 1: welcome text then a blank frame
        foreach (hello[i]) send_byte(hello[i]);
        send_frame(64'd0, -1, 8'h00, 82);
        idle(3);
        chk("t1_frame_count", {56'd0, frame_count}, 64'd1);
        chk("t1_err_count", {56'd0, err_count}, 64'd0);

        // 2: corners alive, pulse one cycle after the last cell
        send_frame(64'h8000_0000_0000_0001, -1, 8'h00, 82);
        idle(3);
        chk("t2_board", board, 64'h8000_0000_0000_0001);

        // 3: good A, corrupted B, good C
        fa  = 64'h0F0F_00FF_A5A5_3C3C;
        fcc = 64'h1234_5678_9ABC_DEF0;
        send_frame(fa, -1, 8'h00, 82);
        send_frame(64'hFFFF_FFFF_FFFF_FFFF, 36, 8'h58, 82);
        idle(2);
        chk("t3_board_kept", board, fa);
        send_frame(fcc, -1, 8'h00, 82);
        idle(3);
        chk("t3_board_c", board, fcc);

        // 4: frame cut by ESC mid row 5, resync on D
        fd = 64'hDEAD_BEEF_0123_4567;
        send_frame(64'h5555_5555_5555_5555, -1, 8'h00, 57);
        push_err();
        send_frame(fd, -1, 8'h00, 82);
        idle(3);
        chk("t4_board", board, fd);

        // 5: reset after row 4 of E, rest of E, then F
        fe = 64'hFFFF_0000_FFFF_0000;
        ff = 64'h8421_8421_1248_1248;
        send_frame(fe, -1, 8'h00, 54);
        do_reset();
        gen_frame(fe);
        for (int i = 54; i < 82; i++) send_byte(fq[i]);
        send_frame(ff, -1, 8'h00, 82);
        idle(3);
        chk("t5_board", board, ff);
        chk("t5_frame_count", {56'd0, frame_count}, 64'd1);
        chk("t5_err_count", {56'd0, err_count}, 64'd0);

        // 6a: error counter saturation
        do_reset();
        for (int k = 0; k < 300; k++) send_frame(64'd0, 4, 8'h58, 5);
        idle(3);
        chk("t6_err_sat", {56'd0, err_count}, 64'd255);

        // 6b: frame counter wrap at full rate
        do_reset();
        for (int k = 0; k < 300; k++)
            send_frame(64'h0123_4567_89AB_CDEF ^ {32'(k), 32'(k * 7)}, -1, 8'h00, 82);
        idle(3);
        chk("t6_frame_wrap", {56'd0, frame_count}, 64'd44);
        chk("t6_no_errors", {56'd0, err_count}, 64'd0);

        for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
